// File: rtl/acc_multi_block_ctrl.sv
// Multi-block hash accelerator controller: fetches message blocks, sequences
// the scheduler and compressor per block, then writes digest and status to the ACB.
module acc_multi_block_ctrl #(
    parameter int          MEM_LISTEN_ADDR_SIZE = 16,
    parameter int          MEM_LISTEN_DATA_SIZE = 32,
    parameter int          MEM_READ_ADDR_SIZE   = 16,
    parameter int          MEM_READ_DATA_SIZE   = 512,
    parameter int          MEM_WRITE_ADDR_SIZE  = 16,
    parameter int          MEM_WRITE_DATA_SIZE  = 32,
    parameter int          HASH_CYCLE_COUNT     = 64,
    parameter int          MAX_BLOCKS           = 4,
    parameter logic [15:0] HCB_MSG_ADDR         = 16'h1008,
    parameter logic [15:0] MSG_STRIDE           = 16'h0040,
    parameter logic [15:0] ACB_START_ADDR       = 16'h5000,
    parameter logic [15:0] ACB_H0_ADDR          = 16'h5008,
    parameter logic [15:0] WORD_ADDR_STEP       = 16'h0004
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mem_listen_en,
    input  logic [MEM_LISTEN_ADDR_SIZE-1:0]       mem_listen_addr,
    input  logic [MEM_LISTEN_DATA_SIZE-1:0]       mem_listen_data,
    output logic                                  mem_acc_read_en,
    output logic [MEM_READ_ADDR_SIZE-1:0]         mem_acc_read_addr,
    input  logic [MEM_READ_DATA_SIZE-1:0]         mem_acc_read_data,
    input  logic                                  mem_acc_read_data_valid,
    output logic                                  mem_acc_write_en,
    output logic [MEM_WRITE_ADDR_SIZE-1:0]        mem_acc_write_addr,
    output logic [MEM_WRITE_DATA_SIZE-1:0]        mem_acc_write_data,
    input  logic                                  mem_acc_write_done,
    input  logic [255:0]                          cm_out,
    output logic [MEM_READ_DATA_SIZE-1:0]         ms_msg,
    output logic                                  ms_init,
    output logic                                  ms_enable,
    output logic                                  cm_rst_hash,
    output logic                                  cm_update_A_H,
    output logic                                  cm_update_H0_7,
    output logic                                  cm_is_hashing,
    output logic [$clog2(HASH_CYCLE_COUNT)-1:0]   cm_cycle_count,
    output logic [$clog2(MAX_BLOCKS):0]           blk_idx,
    output logic                                  busy,
    output logic                                  job_done
);
    localparam int LA = MEM_LISTEN_ADDR_SIZE;
    localparam int RA = MEM_READ_ADDR_SIZE;
    localparam int WA = MEM_WRITE_ADDR_SIZE;
    localparam int W  = MEM_WRITE_DATA_SIZE;
    localparam int CW = $clog2(HASH_CYCLE_COUNT);
    localparam int BW = $clog2(MAX_BLOCKS) + 1;
    localparam int NW = 256 / W;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ_MSG,
        S_WR_BUSY,
        S_INIT,
        S_UPD1,
        S_HASH,
        S_UPD2,
        S_NEXT,
        S_WR_HASH,
        S_STATUS
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [BW-1:0]                 r_blk, w_blk_nxt;
    logic [BW-1:0]                 r_nblk, w_nblk_nxt;
    logic [CW-1:0]                 r_cyc, w_cyc_nxt;
    logic [WW-1:0]                 r_word, w_word_nxt;
    logic [2:0]                    r_code, w_code_nxt;
    logic                          r_abort, w_abort_nxt;
    logic [MEM_READ_DATA_SIZE-1:0] r_msg;
    logic                          w_msg_load;

    logic                          w_cmd;
    logic                          w_start;
    logic                          w_abrt;
    logic [7:0]                    w_nblk;
    logic                          w_nblk_ok;
    logic [NW-1:0][W-1:0]          w_words;
    logic                          w_unused;

    assign w_cmd     = mem_listen_en && (mem_listen_addr == LA'(ACB_START_ADDR));
    assign w_start   = w_cmd && mem_listen_data[0];
    assign w_abrt    = w_cmd && mem_listen_data[1];
    assign w_nblk    = mem_listen_data[15:8];
    assign w_nblk_ok = (w_nblk != 8'd0) && (int'(w_nblk) <= MAX_BLOCKS);
    assign w_words   = cm_out;
    assign w_unused  = ^mem_listen_data;

    assign ms_msg         = r_msg;
    assign blk_idx        = r_blk;
    assign cm_cycle_count = r_cyc;
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_blk   <= '0;
            r_nblk  <= '0;
            r_cyc   <= '0;
            r_word  <= '0;
            r_code  <= '0;
            r_abort <= 1'b0;
            r_msg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_blk   <= w_blk_nxt;
            r_nblk  <= w_nblk_nxt;
            r_cyc   <= w_cyc_nxt;
            r_word  <= w_word_nxt;
            r_code  <= w_code_nxt;
            r_abort <= w_abort_nxt;
            if (w_msg_load) r_msg <= mem_acc_read_data;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_blk_nxt          = r_blk;
        w_nblk_nxt         = r_nblk;
        w_cyc_nxt          = r_cyc;
        w_word_nxt         = r_word;
        w_code_nxt         = r_code;
        w_abort_nxt        = r_abort;
        w_msg_load         = 1'b0;
        mem_acc_read_en    = 1'b0;
        mem_acc_read_addr  = '0;
        mem_acc_write_en   = 1'b0;
        mem_acc_write_addr = '0;
        mem_acc_write_data = '0;
        ms_init            = 1'b0;
        ms_enable          = 1'b0;
        cm_rst_hash        = 1'b0;
        cm_update_A_H      = 1'b0;
        cm_update_H0_7     = 1'b0;
        cm_is_hashing      = 1'b0;
        job_done           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_start) begin
                    if (w_nblk_ok) begin
                        w_nblk_nxt  = BW'(w_nblk);
                        w_blk_nxt   = '0;
                        w_state_nxt = S_READ_MSG;
                    end else begin
                        w_code_nxt  = 3'b110;
                        w_state_nxt = S_STATUS;
                    end
                end
            end
            S_READ_MSG: begin
                mem_acc_read_en   = 1'b1;
                mem_acc_read_addr = RA'(HCB_MSG_ADDR)
                                  + RA'(r_blk) * RA'(MSG_STRIDE);
                if (w_abrt) w_abort_nxt = 1'b1;
                if (mem_acc_read_data_valid) begin
                    w_msg_load = 1'b1;
                    if (r_abort || w_abrt) begin
                        w_code_nxt  = 3'b100;
                        w_state_nxt = S_STATUS;
                    end else if (r_blk == '0) begin
                        w_state_nxt = S_WR_BUSY;
                    end else begin
                        w_state_nxt = S_UPD1;
                    end
                end
            end
            S_WR_BUSY: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = WA'(ACB_START_ADDR);
                mem_acc_write_data = W'(3'b101);
                if (w_abrt) w_abort_nxt = 1'b1;
                if (mem_acc_write_done) begin
                    if (r_abort || w_abrt) begin
                        w_code_nxt  = 3'b100;
                        w_state_nxt = S_STATUS;
                    end else begin
                        w_state_nxt = S_INIT;
                    end
                end
            end
            S_INIT: begin
                cm_rst_hash = 1'b1;
                w_state_nxt = S_UPD1;
                if (w_abrt) begin
                    w_code_nxt  = 3'b100;
                    w_state_nxt = S_STATUS;
                end
            end
            S_UPD1: begin
                cm_update_A_H = 1'b1;
                ms_init       = 1'b1;
                w_state_nxt   = S_HASH;
                if (w_abrt) begin
                    w_code_nxt  = 3'b100;
                    w_state_nxt = S_STATUS;
                end
            end
            S_HASH: begin
                cm_is_hashing = 1'b1;
                ms_enable     = 1'b1;
                w_cyc_nxt     = r_cyc + CW'(1);
                if (w_abrt) begin
                    w_cyc_nxt   = '0;
                    w_code_nxt  = 3'b100;
                    w_state_nxt = S_STATUS;
                end else if (r_cyc == CW'(HASH_CYCLE_COUNT - 1)) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = S_UPD2;
                end
            end
            S_UPD2: begin
                cm_update_H0_7 = 1'b1;
                w_state_nxt    = S_NEXT;
                if (w_abrt) begin
                    w_code_nxt  = 3'b100;
                    w_state_nxt = S_STATUS;
                end
            end
            S_NEXT: begin
                if (w_abrt) begin
                    w_code_nxt  = 3'b100;
                    w_state_nxt = S_STATUS;
                end else if ((r_blk + BW'(1)) < r_nblk) begin
                    w_blk_nxt   = r_blk + BW'(1);
                    w_state_nxt = S_READ_MSG;
                end else begin
                    w_word_nxt  = '0;
                    w_state_nxt = S_WR_HASH;
                end
            end
            S_WR_HASH: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = WA'(ACB_H0_ADDR)
                                   + WA'(r_word) * WA'(WORD_ADDR_STEP);
                mem_acc_write_data = w_words[r_word];
                if (w_abrt) w_abort_nxt = 1'b1;
                // the in-flight word always lands before an abort takes effect
                if (mem_acc_write_done) begin
                    if (r_abort || w_abrt) begin
                        w_code_nxt  = 3'b100;
                        w_state_nxt = S_STATUS;
                    end else if (r_word == WW'(NW - 1)) begin
                        w_code_nxt  = 3'b010;
                        w_state_nxt = S_STATUS;
                    end else begin
                        w_word_nxt = r_word + WW'(1);
                    end
                end
            end
            S_STATUS: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = WA'(ACB_START_ADDR);
                mem_acc_write_data = W'(r_code);
                if (mem_acc_write_done) begin
                    job_done    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_acc_multi_block_ctrl.sv
// Directed + randomized bench for acc_multi_block_ctrl with a stalling arbiter
// and a transaction-level expectation model.
module tb_acc_multi_block_ctrl;
    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    logic         clk;
    logic         rst;
    logic         mem_listen_en;
    logic [15:0]  mem_listen_addr;
    logic [31:0]  mem_listen_data;
    logic         mem_acc_read_en;
    logic [15:0]  mem_acc_read_addr;
    logic [511:0] mem_acc_read_data;
    logic         mem_acc_read_data_valid;
    logic         mem_acc_write_en;
    logic [15:0]  mem_acc_write_addr;
    logic [31:0]  mem_acc_write_data;
    logic         mem_acc_write_done;
    logic [255:0] cm_out;
    logic [511:0] ms_msg;
    logic         ms_init;
    logic         ms_enable;
    logic         cm_rst_hash;
    logic         cm_update_A_H;
    logic         cm_update_H0_7;
    logic         cm_is_hashing;
    logic [5:0]   cm_cycle_count;
    logic [2:0]   blk_idx;
    logic         busy;
    logic         job_done;

    int total = 0;
    int bad = 0;

    int max_stall = 0;
    logic [15:0] fix_addr = 16'hFFFF;
    int fix_stall = 0;
    logic [511:0] last_rdata = '0;

    logic [15:0] rd_q[$];
    int          blk_q[$];
    wr_t         wr_q[$];
    int n_hash = 0;
    int n_rsth = 0;
    int n_done = 0;

    logic [15:0] exp_rd[$];
    wr_t         exp_wr[$];
    int s_rd, s_wr, s_hash, s_rsth, s_done;

    acc_multi_block_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_listen_en           (mem_listen_en),
        .mem_listen_addr         (mem_listen_addr),
        .mem_listen_data         (mem_listen_data),
        .mem_acc_read_en         (mem_acc_read_en),
        .mem_acc_read_addr       (mem_acc_read_addr),
        .mem_acc_read_data       (mem_acc_read_data),
        .mem_acc_read_data_valid (mem_acc_read_data_valid),
        .mem_acc_write_en        (mem_acc_write_en),
        .mem_acc_write_addr      (mem_acc_write_addr),
        .mem_acc_write_data      (mem_acc_write_data),
        .mem_acc_write_done      (mem_acc_write_done),
        .cm_out                  (cm_out),
        .ms_msg                  (ms_msg),
        .ms_init                 (ms_init),
        .ms_enable               (ms_enable),
        .cm_rst_hash             (cm_rst_hash),
        .cm_update_A_H           (cm_update_A_H),
        .cm_update_H0_7          (cm_update_H0_7),
        .cm_is_hashing           (cm_is_hashing),
        .cm_cycle_count          (cm_cycle_count),
        .blk_idx                 (blk_idx),
        .busy                    (busy),
        .job_done                (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    // Arbiter: each request waits a random (or pinned) number of cycles
    bit r_act = 0;
    bit w_act = 0;
    int r_wait = 0;
    int w_wait = 0;
    always @(negedge clk) begin
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done = 1'b0;
        if (rst) begin
            r_act = 0;
            w_act = 0;
        end else begin
            if (mem_acc_read_en) begin
                if (!r_act) begin
                    r_act = 1;
                    r_wait = $urandom_range(max_stall, 0);
                end
                if (r_wait == 0) begin
                    for (int k = 0; k < 16; k++) mem_acc_read_data[k*32 +: 32] = $urandom;
                    last_rdata = mem_acc_read_data;
                    mem_acc_read_data_valid = 1'b1;
                    r_act = 0;
                end else r_wait--;
            end
            if (mem_acc_write_en) begin
                if (!w_act) begin
                    w_act = 1;
                    w_wait = (mem_acc_write_addr == fix_addr) ? fix_stall
                           : $urandom_range(max_stall, 0);
                end
                if (w_wait == 0) begin
                    mem_acc_write_done = 1'b1;
                    w_act = 0;
                end else w_wait--;
            end
        end
    end

    // Monitor: completed transactions, strobe counts, request stability
    logic        p_ren = 0, p_rg = 0, p_wen = 0, p_wg = 0;
    logic [15:0] p_raddr = 0, p_waddr = 0;
    logic [31:0] p_wdata = 0;
    wr_t e;
    always begin
        @(negedge clk);
        #2;
        if (mem_acc_read_en && p_ren && !p_rg)
            check("rd_hold", mem_acc_read_addr, p_raddr);
        if (mem_acc_write_en && p_wen && !p_wg)
            check("wr_hold", {mem_acc_write_addr, mem_acc_write_data}, {p_waddr, p_wdata});
        if (mem_acc_read_en && mem_acc_read_data_valid) begin
            rd_q.push_back(mem_acc_read_addr);
            blk_q.push_back(int'(blk_idx));
        end
        if (mem_acc_write_en && mem_acc_write_done) begin
            e.a = mem_acc_write_addr;
            e.d = mem_acc_write_data;
            wr_q.push_back(e);
        end
        if (cm_is_hashing) n_hash++;
        if (cm_rst_hash) n_rsth++;
        if (job_done) n_done++;
        p_ren = mem_acc_read_en;
        p_rg = mem_acc_read_data_valid;
        p_raddr = mem_acc_read_addr;
        p_wen = mem_acc_write_en;
        p_wg = mem_acc_write_done;
        p_waddr = mem_acc_write_addr;
        p_wdata = mem_acc_write_data;
    end

    task automatic send_cmd(input logic [7:0] n, input logic st, input logic ab);
        mem_listen_en = 1'b1;
        mem_listen_addr = 16'h5000;
        mem_listen_data = {16'h0, n, 6'h0, ab, st};
        tick();
        mem_listen_en = 1'b0;
        mem_listen_data = '0;
    endtask

    task automatic new_cm();
        for (int k = 0; k < 8; k++) cm_out[k*32 +: 32] = $urandom;
    endtask

    task automatic snap();
        s_rd = rd_q.size();
        s_wr = wr_q.size();
        s_hash = n_hash;
        s_rsth = n_rsth;
        s_done = n_done;
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic add_wr(input logic [15:0] a, input logic [31:0] d);
        wr_t x;
        x.a = a;
        x.d = d;
        exp_wr.push_back(x);
    endtask

    task automatic add_digest(input int nw);
        for (int i = 0; i < nw; i++)
            add_wr(16'(16'h5008 + 4 * i), cm_out[i*32 +: 32]);
    endtask

    task automatic wait_idle(input int lim);
        int c = 0;
        while (busy && c < lim) begin
            tick();
            c++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic cmp_txn(input string tag);
        check({tag, "_nrd"}, rd_q.size() - s_rd, exp_rd.size());
        for (int i = 0; i < exp_rd.size(); i++)
            if (s_rd + i < rd_q.size()) check({tag, "_rd"}, rd_q[s_rd+i], exp_rd[i]);
        check({tag, "_nwr"}, wr_q.size() - s_wr, exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (s_wr + i < wr_q.size()) check({tag, "_wr"}, wr_q[s_wr+i], exp_wr[i]);
    endtask

    task automatic run_job(input int n);
        bit ok;
        ok = (n >= 1) && (n <= 4);
        new_cm();
        snap();
        if (ok) begin
            for (int b = 0; b < n; b++) exp_rd.push_back(16'(16'h1008 + b * 16'h40));
            add_wr(16'h5000, 32'd5);
            add_digest(8);
            add_wr(16'h5000, 32'd2);
        end else begin
            add_wr(16'h5000, 32'd6);
        end
        send_cmd(8'(n), 1'b1, 1'b0);
        wait_idle(3000);
        cmp_txn($sformatf("job%0d", n));
        check("hash_cycles", n_hash - s_hash, ok ? 64 * n : 0);
        check("rst_hash_cnt", n_rsth - s_rsth, ok ? 1 : 0);
        check("job_done_cnt", n_done - s_done, 1);
        if (ok) begin
            check("ms_msg_last", ms_msg === last_rdata, 1);
            for (int b = 0; b < n; b++)
                if (s_rd + b < blk_q.size()) check("blk_idx", blk_q[s_rd+b], b);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1;
        mem_listen_en = 1'b0;
        mem_listen_addr = '0;
        mem_listen_data = '0;
        mem_acc_read_data = '0;
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done = 1'b0;
        cm_out = '0;
        repeat (3) tick();

        check("rst_ctl", {busy, mem_acc_read_en, mem_acc_write_en, ms_init, ms_enable,
                          cm_rst_hash, cm_update_A_H, cm_update_H0_7, cm_is_hashing,
                          job_done}, 0);
        check("rst_cnt", {blk_idx, cm_cycle_count}, 0);
        check("rst_bus", {mem_acc_read_addr, mem_acc_write_addr, mem_acc_write_data}, 0);
        check("rst_msg", |ms_msg, 0);
        rst = 1'b0;
        tick();

        send_cmd(8'd1, 1'b0, 1'b1);
        check("idle_abort", busy, 0);

        max_stall = 0;
        run_job(1);
        max_stall = 3;
        run_job(3);
        run_job(0);
        run_job(5);

        // abort while hashing cycle 10 of block 0
        max_stall = 2;
        new_cm();
        snap();
        exp_rd.push_back(16'h1008);
        add_wr(16'h5000, 32'd5);
        add_wr(16'h5000, 32'd4);
        send_cmd(8'd2, 1'b1, 1'b0);
        c = 0;
        while (!(cm_is_hashing && cm_cycle_count == 6'd10) && c < 2000) begin
            tick();
            c++;
        end
        check("reach_hash10", {cm_is_hashing, cm_cycle_count}, {1'b1, 6'd10});
        send_cmd(8'd0, 1'b0, 1'b1);
        check("abort_status", {cm_is_hashing, mem_acc_write_en, mem_acc_write_addr,
                               mem_acc_write_data}, {1'b0, 1'b1, 16'h5000, 32'd4});
        wait_idle(200);
        cmp_txn("abort_hash");
        check("abort_hash_cyc", n_hash - s_hash, 11);
        check("abort_hash_done", n_done - s_done, 1);

        // abort during digest word 3 whose completion is delayed
        max_stall = 0;
        fix_addr = 16'h5014;
        fix_stall = 5;
        new_cm();
        snap();
        exp_rd.push_back(16'h1008);
        add_wr(16'h5000, 32'd5);
        add_digest(4);
        add_wr(16'h5000, 32'd4);
        send_cmd(8'd1, 1'b1, 1'b0);
        c = 0;
        while (!(mem_acc_write_en && mem_acc_write_addr == 16'h5014) && c < 2000) begin
            tick();
            c++;
        end
        check("reach_word3", {mem_acc_write_en, mem_acc_write_addr}, {1'b1, 16'h5014});
        send_cmd(8'd0, 1'b0, 1'b1);
        wait_idle(200);
        fix_addr = 16'hFFFF;
        cmp_txn("abort_wr");
        check("abort_wr_done", n_done - s_done, 1);

        // reset while fetching block 1 under random stalls
        max_stall = 7;
        new_cm();
        send_cmd(8'd2, 1'b1, 1'b0);
        c = 0;
        while (!(mem_acc_read_en && mem_acc_read_addr == 16'h1048) && c < 3000) begin
            tick();
            c++;
        end
        check("reach_rd1", {mem_acc_read_en, mem_acc_read_addr}, {1'b1, 16'h1048});
        snap();
        rst = 1'b1;
        tick();
        check("mid_rst_ctl", {busy, mem_acc_read_en, mem_acc_write_en, cm_is_hashing,
                              ms_enable, job_done}, 0);
        check("mid_rst_cnt", {blk_idx, cm_cycle_count, mem_acc_read_addr}, 0);
        check("mid_rst_msg", |ms_msg, 0);
        rst = 1'b0;
        repeat (4) tick();
        check("mid_rst_nowr", wr_q.size() - s_wr, 0);
        check("mid_rst_nodone", n_done - s_done, 0);

        for (int j = 0; j < 4; j++) begin
            max_stall = $urandom_range(3, 0);
            run_job(int'($urandom_range(5, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
